dc_mem_responder: RTL and testbench

- Memory-side responder for the data cache refill/writeback port; it is the target end of the mem_req/mem_resp handshake that the cache drives as initiator.
- Backs a beat-addressed storage array. Accepts single-beat writebacks and line-read requests, then streams DATA_CYCLES response beats.
- Programmable read latency and periodic NACK injection exercise the cache's retry path in simulation and FPGA bring-up.

---
 rtl/dc_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_dc_mem_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_mem_responder.sv
// dc_mem_responder: memory-side target of the data cache mem_req/mem_resp port.
// Stores beats in a beat-addressed array. It accepts single-beat writebacks and
// line reads, and answers each read with DATA_CYCLES contiguous beats after a
// programmable latency. It can NACK every NACK_PERIOD-th read to exercise the
// initiator's retry path.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   mem_req_val    request valid
//   mem_req_rdy    responder idle and able to accept (combinational)
//   mem_req_rw     1 = write beat, 0 = line read
//   mem_req_addr   beat address (line offset bits ignored for reads)
//   mem_req_data   write beat data
//   mem_req_tag    request tag
//   mem_resp_val   read beat valid (registered)
//   mem_resp_nack  read rejected, initiator must retry (registered)
//   mem_resp_data  read beat data (registered)
//   mem_resp_tag   tag of the read being answered (registered)
module dc_mem_responder #(
    parameter int unsigned MEM_DATA_BITS = 128,
    parameter int unsigned DATA_CYCLES   = 4,
    parameter int unsigned ADDR_BITS     = 26,
    parameter int unsigned DEPTH_LOG2    = 12,
    parameter int unsigned TAG_BITS      = 1,
    parameter int unsigned LATENCY       = 3,
    parameter int unsigned NACK_PERIOD   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_val,
    output logic                     mem_req_rdy,
    input  logic                     mem_req_rw,
    input  logic [ADDR_BITS-1:0]     mem_req_addr,
    input  logic [MEM_DATA_BITS-1:0] mem_req_data,
    input  logic [TAG_BITS-1:0]      mem_req_tag,
    output logic                     mem_resp_val,
    output logic                     mem_resp_nack,
    output logic [MEM_DATA_BITS-1:0] mem_resp_data,
    output logic [TAG_BITS-1:0]      mem_resp_tag
);

    localparam int unsigned OFF_BITS  = $clog2(DATA_CYCLES);
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned LAT_W     = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int unsigned LAT_INIT  = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam int unsigned NACK_W    = (NACK_PERIOD > 1) ? $clog2(NACK_PERIOD) : 1;
    localparam int unsigned NACK_LAST = (NACK_PERIOD > 0) ? NACK_PERIOD - 1 : 0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StNack,
        StResp
    } state_e;

    logic [MEM_DATA_BITS-1:0] mem [DEPTH];

    state_e                         state_q, state_d;
    logic [LAT_W-1:0]               lat_cnt_q, lat_cnt_d;
    logic [OFF_BITS-1:0]            beat_cnt_q, beat_cnt_d;
    logic [NACK_W-1:0]              nack_cnt_q, nack_cnt_d;
    logic                           nack_pending_q, nack_pending_d;
    logic [DEPTH_LOG2-OFF_BITS-1:0] line_q, line_d;
    logic [TAG_BITS-1:0]            tag_q, tag_d;
    logic                           resp_val_q, resp_val_d;
    logic                           resp_nack_q, resp_nack_d;
    logic [MEM_DATA_BITS-1:0]       resp_data_q, resp_data_d;
    logic [TAG_BITS-1:0]            resp_tag_q, resp_tag_d;

    logic                  accept;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  unused_addr;

    // Upper address bits alias onto the storage array.
    assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign mem_req_rdy = (state_q == StIdle) & ~reset;
    assign accept      = mem_req_val & mem_req_rdy;
    assign wr_idx      = mem_req_addr[DEPTH_LOG2-1:0];

    always_comb begin
        state_d        = state_q;
        lat_cnt_d      = lat_cnt_q;
        beat_cnt_d     = beat_cnt_q;
        nack_cnt_d     = nack_cnt_q;
        nack_pending_d = nack_pending_q;
        line_d         = line_q;
        tag_d          = tag_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !mem_req_rw) begin
                    line_d     = mem_req_addr[DEPTH_LOG2-1:OFF_BITS];
                    tag_d      = mem_req_tag;
                    beat_cnt_d = '0;
                    if (NACK_PERIOD != 0) begin
                        if (nack_cnt_q == NACK_W'(NACK_LAST)) begin
                            nack_pending_d = 1'b1;
                            nack_cnt_d     = '0;
                        end else begin
                            nack_cnt_d = nack_cnt_q + 1'b1;
                        end
                    end
                    if (LATENCY == 1) begin
                        state_d = nack_pending_d ? StNack : StResp;
                    end else begin
                        state_d   = StWait;
                        lat_cnt_d = LAT_W'(LAT_INIT);
                    end
                end
            end
            StWait: begin
                if (lat_cnt_q == '0) begin
                    state_d = nack_pending_q ? StNack : StResp;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            StNack: begin
                state_d        = StIdle;
                nack_pending_d = 1'b0;
            end
            StResp: begin
                // Wraps modulo DATA_CYCLES; the line base is never advanced.
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == OFF_BITS'(DATA_CYCLES - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so the storage read for the beat shown next cycle
    // is taken from the next-state line/beat during this cycle.
    always_comb begin
        rd_idx      = {line_d, beat_cnt_d};
        resp_val_d  = (state_d == StResp);
        resp_nack_d = (state_d == StNack);
        resp_data_d = resp_val_d ? mem[rd_idx] : resp_data_q;
        resp_tag_d  = (resp_val_d || resp_nack_d) ? tag_d : resp_tag_q;
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (accept && mem_req_rw) begin
            mem[wr_idx] <= mem_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            lat_cnt_q      <= '0;
            beat_cnt_q     <= '0;
            nack_cnt_q     <= '0;
            nack_pending_q <= 1'b0;
            line_q         <= '0;
            tag_q          <= '0;
            resp_val_q     <= 1'b0;
            resp_nack_q    <= 1'b0;
            resp_data_q    <= '0;
            resp_tag_q     <= '0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            beat_cnt_q     <= beat_cnt_d;
            nack_cnt_q     <= nack_cnt_d;
            nack_pending_q <= nack_pending_d;
            line_q         <= line_d;
            tag_q          <= tag_d;
            resp_val_q     <= resp_val_d;
            resp_nack_q    <= resp_nack_d;
            resp_data_q    <= resp_data_d;
            resp_tag_q     <= resp_tag_d;
        end
    end

    assign mem_resp_val  = resp_val_q;
    assign mem_resp_nack = resp_nack_q;
    assign mem_resp_data = resp_data_q;
    assign mem_resp_tag  = resp_tag_q;

endmodule

// File: tb/tb_dc_mem_responder.sv
// Bench for dc_mem_responder. Instance A uses LATENCY=3 without NACKs; instance B
// uses LATENCY=1, NACK_PERIOD=2 and a 16-beat array to exercise aliasing.
// Expected beats come from a bench-side memory model and are queued when a read
// is issued, then popped as the DUT produces beats.
module tb_dc_mem_responder;

    localparam int unsigned DW      = 128;
    localparam int unsigned DC      = 4;
    localparam int unsigned AW      = 26;
    localparam int unsigned LAT_A   = 3;
    localparam int unsigned LAT_B   = 1;
    localparam int unsigned NACK_B  = 2;
    localparam int unsigned DEPTH_A = 12;
    localparam int unsigned DEPTH_B = 4;

    typedef struct {
        logic          nack;
        logic [DW-1:0] data;
        logic          tag;
        int            cyc;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] model_a [int];
    logic [DW-1:0] model_b [int];
    int            checks   = 0;
    int            errors   = 0;
    int            b_nack_m = 0;

    logic clk = 1'b0;
    logic reset;

    logic          a_req_val, a_req_rdy, a_req_rw, a_req_tag;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_data, a_resp_data;
    logic          a_resp_val, a_resp_nack, a_resp_tag;

    logic          b_req_val, b_req_rdy, b_req_rw, b_req_tag;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_data, b_resp_data;
    logic          b_resp_val, b_resp_nack, b_resp_tag;

    always #5 clk = ~clk;

    dc_mem_responder #(
        .MEM_DATA_BITS(DW), .DATA_CYCLES(DC), .ADDR_BITS(AW), .DEPTH_LOG2(DEPTH_A),
        .TAG_BITS(1), .LATENCY(LAT_A), .NACK_PERIOD(0)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .mem_req_val(a_req_val), .mem_req_rdy(a_req_rdy), .mem_req_rw(a_req_rw),
        .mem_req_addr(a_req_addr), .mem_req_data(a_req_data), .mem_req_tag(a_req_tag),
        .mem_resp_val(a_resp_val), .mem_resp_nack(a_resp_nack),
        .mem_resp_data(a_resp_data), .mem_resp_tag(a_resp_tag)
    );

    dc_mem_responder #(
        .MEM_DATA_BITS(DW), .DATA_CYCLES(DC), .ADDR_BITS(AW), .DEPTH_LOG2(DEPTH_B),
        .TAG_BITS(1), .LATENCY(LAT_B), .NACK_PERIOD(NACK_B)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .mem_req_val(b_req_val), .mem_req_rdy(b_req_rdy), .mem_req_rw(b_req_rw),
        .mem_req_addr(b_req_addr), .mem_req_data(b_req_data), .mem_req_tag(b_req_tag),
        .mem_resp_val(b_resp_val), .mem_resp_nack(b_resp_nack),
        .mem_resp_data(b_resp_data), .mem_resp_tag(b_resp_tag)
    );

    // Stimulus helpers (drive only); called at a negedge with the DUT idle.
    task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_req_val = 1'b1; a_req_rw = 1'b1; a_req_addr = addr; a_req_data = data;
        model_a[int'(addr) & ((1 << DEPTH_A) - 1)] = data;
        @(negedge clk);
        a_req_val = 1'b0; a_req_rw = 1'b0;
    endtask

    task automatic write_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        b_req_val = 1'b1; b_req_rw = 1'b1; b_req_addr = addr; b_req_data = data;
        model_b[int'(addr) & ((1 << DEPTH_B) - 1)] = data;
        @(negedge clk);
        b_req_val = 1'b0; b_req_rw = 1'b0;
    endtask

    task automatic push_a(input logic [AW-1:0] addr, input logic tag);
        exp_t e;
        int   base;
        base = int'(addr) & ~(int'(DC) - 1);
        for (int k = 0; k < int'(DC); k++) begin
            e.nack = 1'b0;
            e.data = model_a[(base + k) & ((1 << DEPTH_A) - 1)];
            e.tag  = tag;
            e.cyc  = int'(LAT_A) + k;
            exp_q.push_back(e);
        end
    endtask

    task automatic read_a(input logic [AW-1:0] addr, input logic tag);
        a_req_val = 1'b1; a_req_rw = 1'b0; a_req_addr = addr; a_req_tag = tag;
        push_a(addr, tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (a_resp_val !== 1'b0 || a_resp_nack !== 1'b0) begin
            errors++;
            $display("FAIL rst_a_valnack: val=%b nack=%b required 0 0", a_resp_val, a_resp_nack);
        end
        checks++;
        if (a_resp_data !== '0 || a_resp_tag !== 1'b0) begin
            errors++;
            $display("FAIL rst_a_datatag: data=%h tag=%b required 0", a_resp_data, a_resp_tag);
        end
        checks++;
        if (a_req_rdy !== 1'b0 || b_req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_rdy_low: a=%b b=%b required 0 0", a_req_rdy, b_req_rdy);
        end
        checks++;
        if (b_resp_val !== 1'b0 || b_resp_nack !== 1'b0 || b_resp_data !== '0) begin
            errors++;
            $display("FAIL rst_b_outputs: val=%b nack=%b data=%h required 0", b_resp_val,
                     b_resp_nack, b_resp_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (a_req_rdy !== 1'b1 || b_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rst_rdy_release: a=%b b=%b required 1 1", a_req_rdy, b_req_rdy);
        end
        @(negedge clk);
    endtask

    // Back-to-back writes, then a read from mid-line address 0x41. A write
    // presented while busy must be ignored.
    task automatic test_line_read();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_req_rdy !== 1'b1) begin
                errors++;
                $display("FAIL lr_wr_rdy[%0d]: rdy=%b required 1", i, a_req_rdy);
            end
            write_a(AW'(32'h40 + 32'(i)), {4{32'hA000_0000 + 32'(i)}});
        end
        read_a(AW'(32'h41), 1'b1);
        @(negedge clk);
        a_req_rw = 1'b1; a_req_data = '1;
        for (int c = 1; c <= int'(LAT_A + DC) + 1; c++) begin
            checks++;
            if (a_resp_nack !== 1'b0) begin
                errors++;
                $display("FAIL lr_nack c=%0d: nack=%b required 0", c, a_resp_nack);
            end
            checks++;
            if (a_req_rdy !== (c >= int'(LAT_A + DC))) begin
                errors++;
                $display("FAIL lr_rdy c=%0d: rdy=%b required %b", c, a_req_rdy,
                         (c >= int'(LAT_A + DC)));
            end
            if (a_resp_val === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lr_extra c=%0d: beat=%h required none", c, a_resp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (a_resp_data !== e.data || a_resp_tag !== e.tag || c != e.cyc) begin
                        errors++;
                        $display("FAIL lr_beat c=%0d: data=%h tag=%b required %h tag=%b c=%0d",
                                 c, a_resp_data, a_resp_tag, e.data, e.tag, e.cyc);
                    end
                end
            end
            if (c == 2) a_req_val = 1'b0;
            @(negedge clk);
        end
        a_req_rw = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lr_missing: %0d beats outstanding required 0", exp_q.size());
        end
    endtask

    // A write at edge T must be visible to a read accepted at edge T+1.
    task automatic test_write_read_order();
        exp_t e;
        for (int i = 0; i < 4; i++) write_a(AW'(32'h10 + 32'(i)), {4{32'h0DD0_0000 + 32'(i)}});
        write_a(AW'(32'h10), {4{32'hFEED_1010}});
        read_a(AW'(32'h10), 1'b0);
        @(negedge clk);
        a_req_val = 1'b0;
        for (int c = 1; c <= int'(LAT_A + DC) + 1; c++) begin
            if (a_resp_val === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ord_extra c=%0d: beat=%h required none", c, a_resp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (a_resp_data !== e.data || c != e.cyc) begin
                        errors++;
                        $display("FAIL ord_beat c=%0d: data=%h required %h c=%0d", c,
                                 a_resp_data, e.data, e.cyc);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ord_missing: %0d beats outstanding required 0", exp_q.size());
        end
    endtask

    // Reset during beat 2 aborts the burst; a fresh read returns a full line.
    task automatic test_reset_mid_burst();
        exp_t e;
        for (int i = 0; i < 4; i++) write_a(AW'(32'h20 + 32'(i)), {4{32'hC000_0020 + 32'(i)}});
        read_a(AW'(32'h22), 1'b1);
        @(negedge clk);
        a_req_val = 1'b0;
        for (int c = 1; c <= int'(LAT_A) + 2; c++) begin
            if (a_resp_val === 1'b1) begin
                checks++;
                e = exp_q.pop_front();
                if (a_resp_data !== e.data || c != e.cyc) begin
                    errors++;
                    $display("FAIL rmb_pre c=%0d: data=%h required %h c=%0d", c, a_resp_data,
                             e.data, e.cyc);
                end
            end
            if (c < int'(LAT_A) + 2) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (a_resp_val !== 1'b0 || a_resp_nack !== 1'b0 || a_resp_data !== '0) begin
            errors++;
            $display("FAIL rmb_abort: val=%b nack=%b data=%h required 0", a_resp_val,
                     a_resp_nack, a_resp_data);
        end
        reset = 1'b0;
        b_nack_m = 0;
        exp_q.delete();
        #1;
        checks++;
        if (a_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rmb_rdy: rdy=%b required 1", a_req_rdy);
        end
        read_a(AW'(32'h20), 1'b0);
        @(negedge clk);
        a_req_val = 1'b0;
        for (int c = 1; c <= int'(LAT_A + DC) + 1; c++) begin
            if (a_resp_val === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rmb_extra c=%0d: beat=%h required none", c, a_resp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (a_resp_data !== e.data || a_resp_tag !== e.tag || c != e.cyc) begin
                        errors++;
                        $display("FAIL rmb_beat c=%0d: data=%h tag=%b required %h tag=%b c=%0d",
                                 c, a_resp_data, a_resp_tag, e.data, e.tag, e.cyc);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rmb_missing: %0d beats outstanding required 0", exp_q.size());
        end
    endtask

    // LATENCY=1 streaming, periodic NACKs and index aliasing on instance B.
    task automatic test_b_reads();
        exp_t          e;
        logic [AW-1:0] rd_addr [5];
        logic          rd_tag  [5];
        logic          exp_nack;
        int            last;
        int            base;
        rd_addr[0] = AW'(32'h80); rd_tag[0] = 1'b1;
        rd_addr[1] = AW'(32'h00); rd_tag[1] = 1'b0;
        rd_addr[2] = AW'(32'h00); rd_tag[2] = 1'b1;
        rd_addr[3] = AW'(32'h14); rd_tag[3] = 1'b0;
        rd_addr[4] = AW'(32'h14); rd_tag[4] = 1'b1;
        for (int i = 0; i < 16; i++) write_b(AW'(i), {4{32'hB000_0000 + 32'(i)}});
        write_b(AW'(32'h05), {4{32'h5555_0005}});
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (b_req_rdy !== 1'b1) begin
                errors++;
                $display("FAIL b_idle_rdy[%0d]: rdy=%b required 1", r, b_req_rdy);
            end
            b_req_val = 1'b1; b_req_rw = 1'b0; b_req_addr = rd_addr[r]; b_req_tag = rd_tag[r];
            exp_nack = (b_nack_m == int'(NACK_B) - 1);
            b_nack_m = exp_nack ? 0 : b_nack_m + 1;
            if (exp_nack) begin
                e.nack = 1'b1; e.data = '0; e.tag = rd_tag[r]; e.cyc = int'(LAT_B);
                exp_q.push_back(e);
                last = int'(LAT_B);
            end else begin
                base = int'(rd_addr[r]) & ~(int'(DC) - 1);
                for (int k = 0; k < int'(DC); k++) begin
                    e.nack = 1'b0;
                    e.data = model_b[(base + k) & ((1 << DEPTH_B) - 1)];
                    e.tag  = rd_tag[r];
                    e.cyc  = int'(LAT_B) + k;
                    exp_q.push_back(e);
                end
                last = int'(LAT_B + DC) - 1;
            end
            @(negedge clk);
            b_req_val = 1'b0;
            for (int c = 1; c <= int'(LAT_B + DC) + 1; c++) begin
                checks++;
                if (b_resp_val === 1'b1 && b_resp_nack === 1'b1) begin
                    errors++;
                    $display("FAIL b_excl r=%0d c=%0d: val=1 nack=1 required not both", r, c);
                end
                checks++;
                if (b_req_rdy !== (c > last)) begin
                    errors++;
                    $display("FAIL b_rdy r=%0d c=%0d: rdy=%b required %b", r, c, b_req_rdy,
                             (c > last));
                end
                if (b_resp_val === 1'b1 || b_resp_nack === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL b_extra r=%0d c=%0d: val=%b nack=%b required none", r, c,
                                 b_resp_val, b_resp_nack);
                    end else begin
                        e = exp_q.pop_front();
                        if (b_resp_nack !== e.nack || c != e.cyc ||
                            (!e.nack && (b_resp_data !== e.data || b_resp_tag !== e.tag))) begin
                            errors++;
                            $display("FAIL b_resp r=%0d c=%0d: nack=%b data=%h tag=%b required nack=%b data=%h tag=%b c=%0d",
                                     r, c, b_resp_nack, b_resp_data, b_resp_tag, e.nack,
                                     e.data, e.tag, e.cyc);
                        end
                    end
                end
                @(negedge clk);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL b_missing r=%0d: %0d outstanding required 0", r, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req_val = 1'b0; a_req_rw = 1'b0; a_req_addr = '0; a_req_data = '0; a_req_tag = 1'b0;
        b_req_val = 1'b0; b_req_rw = 1'b0; b_req_addr = '0; b_req_data = '0; b_req_tag = 1'b0;
        test_reset();
        test_line_read();
        test_write_read_order();
        test_reset_mid_burst();
        test_b_reads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
